// File: rtl/arp_req_gen_if.sv
// Miss-request handshake and AXI4-Stream master bundle for arp_req_gen.
// slave: the generator's view; master: the requester/sink (testbench) view.
interface arp_req_gen_if #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128
);
  logic                                miss_valid;
  logic                                miss_ready;
  logic [31:0]                         miss_ip;
  logic [7:0]                          miss_oq;
  logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER;
  logic                                M_AXIS_TVALID;
  logic                                M_AXIS_TREADY;
  logic                                M_AXIS_TLAST;

  modport slave (
    input  miss_valid, miss_ip, miss_oq, M_AXIS_TREADY,
    output miss_ready, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TVALID, M_AXIS_TLAST
  );

  modport master (
    output miss_valid, miss_ip, miss_oq, M_AXIS_TREADY,
    input  miss_ready, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TVALID, M_AXIS_TLAST
  );
endinterface

// File: rtl/arp_req_gen.sv
// Builds a two-beat 42-byte broadcast ARP request per accepted miss on a 256-bit stream.
// Optional duplicate suppression is enabled by defining ARP_REQ_DEDUP_EN.
module arp_req_gen #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned SRC_PORT_POS         = 16,
  parameter int unsigned DST_PORT_POS         = 24,
  parameter int unsigned HOLDOFF_CYCLES       = 1024
) (
  input  logic        AXI_ACLK,
  input  logic        AXI_RESET,
  arp_req_gen_if.slave bus,
  input  logic [47:0] port_mac0,
  input  logic [47:0] port_mac1,
  input  logic [47:0] port_mac2,
  input  logic [47:0] port_mac3,
  input  logic [31:0] port_ip0,
  input  logic [31:0] port_ip1,
  input  logic [31:0] port_ip2,
  input  logic [31:0] port_ip3,
  output logic [31:0] req_sent_count,
  output logic [31:0] req_drop_count,
  output logic [31:0] req_dedup_count
);

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_miss_ip;
  logic [7:0]  r_miss_oq;
  logic [47:0] r_port_mac;
  logic [31:0] r_port_ip;
  logic [31:0] r_sent_cnt;
  logic [31:0] r_drop_cnt;

  logic        w_accept;
  logic        w_port_ok;
  logic        w_dup;
  logic        w_gen;
  logic        w_sent;
  logic [47:0] w_sel_mac;
  logic [31:0] w_sel_ip;

  // Only the four MAC ports (even one-hot bits) are legal destinations.
  always_comb begin
    w_sel_mac = '0;
    w_sel_ip  = '0;
    w_port_ok = 1'b0;
    case (bus.miss_oq)
      8'h01: begin w_sel_mac = port_mac0; w_sel_ip = port_ip0; w_port_ok = 1'b1; end
      8'h04: begin w_sel_mac = port_mac1; w_sel_ip = port_ip1; w_port_ok = 1'b1; end
      8'h10: begin w_sel_mac = port_mac2; w_sel_ip = port_ip2; w_port_ok = 1'b1; end
      8'h40: begin w_sel_mac = port_mac3; w_sel_ip = port_ip3; w_port_ok = 1'b1; end
      default: ;
    endcase
  end

  assign w_accept = bus.miss_valid & bus.miss_ready;
  assign w_gen    = w_accept & w_port_ok & ~w_dup;
  assign w_sent   = (r_state == StBeat1) & bus.M_AXIS_TREADY;

`ifdef ARP_REQ_DEDUP_EN
  localparam int unsigned HoWidth = $clog2(HOLDOFF_CYCLES + 1);

  logic [31:0]         r_last_ip;
  logic [HoWidth-1:0]  r_holdoff;
  logic [31:0]         r_dedup_cnt;

  assign w_dup           = (r_holdoff != '0) && (bus.miss_ip == r_last_ip);
  assign req_dedup_count = r_dedup_cnt;

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      r_last_ip   <= '0;
      r_holdoff   <= '0;
      r_dedup_cnt <= '0;
    end else begin
      if (w_gen) begin
        r_last_ip <= bus.miss_ip;
        r_holdoff <= HoWidth'(HOLDOFF_CYCLES);
      end else if (r_holdoff != '0) begin
        r_holdoff <= r_holdoff - 1'b1;
      end
      if (w_accept && w_port_ok && w_dup) r_dedup_cnt <= r_dedup_cnt + 32'd1;
    end
  end
`else
  assign w_dup           = 1'b0;
  assign req_dedup_count = '0;
`endif

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      r_state    <= StIdle;
      r_miss_ip  <= '0;
      r_miss_oq  <= '0;
      r_port_mac <= '0;
      r_port_ip  <= '0;
      r_sent_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_miss_ip  <= bus.miss_ip;
        r_miss_oq  <= bus.miss_oq;
        r_port_mac <= w_sel_mac;
        r_port_ip  <= w_sel_ip;
      end
      if (w_accept && !w_port_ok) r_drop_cnt <= r_drop_cnt + 32'd1;
      if (w_sent)                 r_sent_cnt <= r_sent_cnt + 32'd1;
    end
  end

  assign req_sent_count = r_sent_cnt;
  assign req_drop_count = r_drop_cnt;

  logic [255:0]                      w_beat0;
  logic [255:0]                      w_beat1;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   w_tuser;

  // Beat 0: Ethernet header plus ARP header up to SPA; beat 1: THA (zero) and TPA.
  assign w_beat0 = {48'hFFFF_FFFF_FFFF, r_port_mac, 16'h0806,
                    16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001,
                    r_port_mac, r_port_ip};
  assign w_beat1 = {48'h0, r_miss_ip, 176'h0};

  always_comb begin
    w_tuser                          = '0;
    w_tuser[15:0]                    = 16'd42;
    w_tuser[SRC_PORT_POS +: 8]       = 8'h00;
    w_tuser[DST_PORT_POS +: 8]       = r_miss_oq;
  end

  always_comb begin
    w_state_next      = r_state;
    bus.miss_ready    = 1'b0;
    bus.M_AXIS_TVALID = 1'b0;
    bus.M_AXIS_TLAST  = 1'b0;
    bus.M_AXIS_TDATA  = '0;
    bus.M_AXIS_TSTRB  = '0;
    bus.M_AXIS_TUSER  = '0;
    unique case (r_state)
      StIdle: begin
        bus.miss_ready = ~AXI_RESET;
        if (w_gen) w_state_next = StBeat0;
      end
      StBeat0: begin
        bus.M_AXIS_TVALID = 1'b1;
        bus.M_AXIS_TDATA  = w_beat0;
        bus.M_AXIS_TSTRB  = 32'hFFFF_FFFF;
        bus.M_AXIS_TUSER  = w_tuser;
        if (bus.M_AXIS_TREADY) w_state_next = StBeat1;
      end
      StBeat1: begin
        bus.M_AXIS_TVALID = 1'b1;
        bus.M_AXIS_TLAST  = 1'b1;
        bus.M_AXIS_TDATA  = w_beat1;
        bus.M_AXIS_TSTRB  = 32'hFFC0_0000;
        bus.M_AXIS_TUSER  = w_tuser;
        if (bus.M_AXIS_TREADY) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

endmodule

// File: doc/arp_req_gen.md
ARP_REQ_GEN -- requirements
Module: arp_req_gen

Interface
REQ-001 The block SHALL have parameter C_M_AXIS_DATA_WIDTH, default 256, master stream data width (only 256 supported).
REQ-002 The block SHALL have parameter C_M_AXIS_TUSER_WIDTH, default 128, master stream TUSER width.
REQ-003 The block SHALL have parameter SRC_PORT_POS, default 16, and DST_PORT_POS, default 24, the TUSER source and destination port byte offsets.
REQ-004 The block SHALL have parameter HOLDOFF_CYCLES, default 1024, the duplicate-suppression window in clocks (used only under REQ-027).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- AXI_ACLK  in  1  sole clock, all logic on rising edge.
- AXI_RESET  in  1  synchronous, active-high reset.
- miss_valid  in  1  an ARP miss request is presented.
- miss_ready  out  1  the miss is accepted when miss_valid and miss_ready are both high.
- miss_ip  in  32  next-hop IPv4 address to resolve.
- miss_oq  in  8  one-hot output port (bit 0, 2, 4 or 6 = MAC port 0..3).
- port_mac0..port_mac3  in  48 each  per-port source MAC.
- port_ip0..port_ip3  in  32 each  per-port source IPv4.
- M_AXIS_TDATA  out  256  frame data; byte 0 at [255:248].
- M_AXIS_TSTRB  out  32  byte strobes; bit 31 = byte 0.
- M_AXIS_TUSER  out  128  NetFPGA metadata.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TLAST  out  1  last beat.
- req_sent_count  out  32  completed ARP requests.
- req_drop_count  out  32  misses dropped for an invalid port.
- req_dedup_count  out  32  misses suppressed as duplicates.

Function
REQ-006 The state machine SHALL have three states: IDLE, BEAT0 and BEAT1.
REQ-007 miss_ready SHALL be 1 only in IDLE.
REQ-008 On an accepted miss, miss_ip and miss_oq SHALL be captured, and the selected port MAC/IP SHALL also be captured.
REQ-009 An accepted miss with a valid port SHALL move IDLE to BEAT0, so that M_AXIS_TVALID rises on the cycle after acceptance.
REQ-010 An accepted miss whose miss_oq is not exactly one of 0x01, 0x04, 0x10 or 0x40 SHALL stay in IDLE, emit nothing and increment req_drop_count.
REQ-011 In BEAT0: TVALID=1, TLAST=0, TSTRB=0xFFFFFFFF; the state SHALL move to BEAT1 only when TREADY=1.
REQ-012 In BEAT1: TVALID=1, TLAST=1, TSTRB=0xFFC00000; the state SHALL move to IDLE when TREADY=1, and req_sent_count SHALL increment in that cycle.
REQ-013 TDATA, TSTRB, TUSER and TLAST SHALL be held stable while TVALID=1 and TREADY=0.
REQ-014 In IDLE, TVALID=0, and TDATA/TSTRB/TLAST SHALL be 0.
REQ-015 Frame bytes 0-5 SHALL be FF:FF:FF:FF:FF:FF; bytes 6-11 SHALL be the port MAC; bytes 12-13 SHALL be 0x0806.
REQ-016 Frame bytes 14-15 SHALL be 0x0001, bytes 16-17 0x0800, byte 18 0x06, byte 19 0x04 and bytes 20-21 0x0001 (request).
REQ-017 Frame bytes 22-27 SHALL be the port MAC (SHA), and bytes 28-31 SHALL be the port IP (SPA).
REQ-018 Frame bytes 32-37 SHALL be zero (THA), and bytes 38-41 SHALL be miss_ip (TPA); in BEAT1 these occupy TDATA[255:176], and the rest of TDATA SHALL be 0.
REQ-019 TUSER SHALL be the same on both beats: [15:0]=42, [SRC_PORT_POS+7:SRC_PORT_POS]=0x00, [DST_PORT_POS+7:DST_PORT_POS]=captured miss_oq, and all other bits 0.
REQ-020 Back-to-back requests SHALL have a minimum spacing of 3 cycles from one acceptance to the next, with no overlap.
REQ-021 All counters SHALL wrap modulo 2^32.

Reset
REQ-022 While AXI_RESET=1 at a clock edge, the state SHALL become IDLE and all counters SHALL become 0.
REQ-023 While AXI_RESET=1 at a clock edge, the captured registers and the hold-off state SHALL become 0.
REQ-024 After reset, M_AXIS_TVALID=0, TLAST=0 and miss_ready=1 (from the first non-reset cycle).
REQ-025 Reset asserted mid-frame SHALL abandon the frame: TVALID SHALL be 0 on the next cycle, and no count SHALL increment.
REQ-026 miss_ready SHALL be 0 during reset.

Configuration
REQ-027 With macro ARP_REQ_DEDUP_EN defined, each frame-generating acceptance SHALL load last_ip=miss_ip and holdoff=HOLDOFF_CYCLES, and holdoff SHALL decrement by 1 per cycle until it reaches 0.
REQ-028 With ARP_REQ_DEDUP_EN defined, an accepted miss with miss_ip==last_ip and holdoff!=0 SHALL stay in IDLE, emit nothing and increment req_dedup_count; the invalid-port check (REQ-010) takes precedence.
REQ-029 Without ARP_REQ_DEDUP_EN, every valid miss SHALL generate a frame, and req_dedup_count SHALL be tied to 0.

Verification
REQ-030 Port-0 request: miss_ip=10.0.1.1, miss_oq=0x01, port_mac0=00:4E:46:32:43:00, port_ip0=10.0.0.1, TREADY=1 -> two beats, beat0 [255:160]=FFFFFFFFFFFF_004E46324300, beat1 [207:176]=0x0A000101, TUSER[31:24]=0x01, [15:0]=42, req_sent_count=1.
REQ-031 Back-pressure: TREADY=0 for 5 cycles in BEAT0, then 3 cycles in BEAT1 -> outputs stable throughout, exactly 2 handshakes, TLAST only on the second.
REQ-032 Invalid port: miss_oq=0x02, then 0x05 -> no TVALID, req_drop_count=2.
REQ-033 Reset pulse in BEAT1 with TREADY=0 -> TVALID=0 next cycle, counters=0, and a new miss is accepted after reset.
REQ-034 With ARP_REQ_DEDUP_EN and HOLDOFF_CYCLES=16: the same IP repeated at cycles 0, 5 and 30 -> frames for the 1st and 3rd only, req_dedup_count=1; without the macro -> 3 frames.
